// File: rtl/bitcoin_header_loader_pkg.sv
// Shared SHA-256 constants, loader FSM states and nBits expansion helpers.
package bitcoin_header_loader_pkg;

    typedef enum logic [1:0] {StLoad, StStart, StWaitHi, StWaitLo} state_e;

    localparam logic [4:0] WordLastBlk = 5'd15;
    localparam logic [4:0] WordNbits   = 5'd18;
    localparam logic [4:0] WordsTotal  = 5'd20;
    localparam logic [5:0] LastRound   = 6'd63;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Overflowing or negative compact targets saturate and skip the increment.
    function automatic logic [255:0] expand_target(input logic [31:0] nbits,
                                                   input logic [255:0] inc);
        int unsigned e;
        logic [255:0] mant;
        e    = 32'(nbits[31:24]);
        mant = 256'(nbits[23:0]);
        if (e > 32 || nbits[23]) return '1;
        if (e <= 3) return (mant >> (8 * (3 - e))) + inc;
        return (mant << (8 * (e - 3))) + inc;
    endfunction

endpackage

// File: rtl/bitcoin_header_loader_if.sv
// Header word stream and miner-facing bus of the header loader.
interface bitcoin_header_loader_if;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         miner_running;
    logic         start;
    logic [255:0] first_block_hash;
    logic [127:0] second_block;
    logic [255:0] target;
    logic [31:0]  max_nonce;
    logic         busy;

    modport slave (
        input  in_valid, in_data, miner_running,
        output in_ready, start, first_block_hash, second_block, target, max_nonce, busy
    );

    modport master (
        output in_valid, in_data, miner_running,
        input  in_ready, start, first_block_hash, second_block, target, max_nonce, busy
    );
endinterface

// File: rtl/bitcoin_header_loader_sha256_round.sv
// Combinational SHA-256 round: {a..h}, K, W -> {a..h}'.
module sha256_round
    import bitcoin_header_loader_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
    assign t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/bitcoin_header_loader.sv
// Loads an 80-byte header, computes the first-block midstate and target, hands off to the miner.
// Define HEADER_BYTE_SWAP_EN to byte-reverse each incoming word (little-endian wire order).
module bitcoin_header_loader
    import bitcoin_header_loader_pkg::*;
#(
    parameter logic [255:0] TARGET_INC = 256'd1
) (
    input logic                     clk,
    input logic                     reset,
    bitcoin_header_loader_if.slave  bus
);
    state_e state_q, state_d;
    logic        clear_hdr;
    logic [4:0]  word_cnt_q;
    logic [15:0][31:0] sched_q;
    logic [3:0][31:0]  second_q;
    logic [255:0] work_q, work_next, midstate, hash_q, target_q;
    logic [5:0]  round_q;
    logic        comp_q, fin_q, hash_done_q;
    logic        accept;
    logic [31:0] word, sched_new;

`ifdef HEADER_BYTE_SWAP_EN
    assign word = byte_swap(bus.in_data);
`else
    assign word = bus.in_data;
`endif

    assign bus.in_ready         = (state_q == StLoad) && (word_cnt_q < WordsTotal);
    assign bus.busy             = !((state_q == StLoad) && (word_cnt_q == 5'd0));
    assign bus.start            = (state_q == StStart);
    assign bus.first_block_hash = hash_q;
    assign bus.second_block     = second_q;
    assign bus.target           = target_q;
    assign bus.max_nonce        = '1;
    assign accept               = bus.in_valid && bus.in_ready;

    // The schedule register slides by one per round, so W[t] is always sched_q[0].
    assign sched_new = small_sigma1(sched_q[14]) + sched_q[9] + small_sigma0(sched_q[1])
                     + sched_q[0];

    sha256_round u_round (
        .state_in  (work_q),
        .k         (K[round_q]),
        .w         (sched_q[0]),
        .state_out (work_next)
    );

    always_comb begin
        midstate = '0;
        for (int i = 0; i < 8; i++) begin
            midstate[i*32 +: 32] = IV[i*32 +: 32] + work_q[i*32 +: 32];
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_hdr = 1'b0;
        unique case (state_q)
            StLoad:   if (word_cnt_q == WordsTotal && hash_done_q) state_d = StStart;
            StStart:  state_d = StWaitHi;
            StWaitHi: if (bus.miner_running) state_d = StWaitLo;
            StWaitLo: begin
                if (!bus.miner_running) begin
                    state_d   = StLoad;
                    clear_hdr = 1'b1;
                end
            end
            default:  state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StLoad;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q  <= '0;
            sched_q     <= '0;
            second_q    <= '0;
            work_q      <= '0;
            hash_q      <= '0;
            target_q    <= '0;
            round_q     <= '0;
            comp_q      <= 1'b0;
            fin_q       <= 1'b0;
            hash_done_q <= 1'b0;
        end else begin
            if (clear_hdr) begin
                word_cnt_q  <= '0;
                hash_done_q <= 1'b0;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + 5'd1;
            end

            if (accept && word_cnt_q <= WordLastBlk) sched_q[word_cnt_q[3:0]] <= word;
            if (accept && word_cnt_q > WordLastBlk) second_q[2'd3 - word_cnt_q[1:0]] <= word;
            if (accept && word_cnt_q == WordNbits) target_q <= expand_target(word, TARGET_INC);

            if (accept && word_cnt_q == WordLastBlk) begin
                work_q  <= IV;
                round_q <= '0;
                comp_q  <= 1'b1;
            end else if (comp_q) begin
                work_q  <= work_next;
                round_q <= round_q + 6'd1;
                for (int i = 0; i < 15; i++) sched_q[i] <= sched_q[i+1];
                sched_q[15] <= sched_new;
                if (round_q == LastRound) begin
                    comp_q <= 1'b0;
                    fin_q  <= 1'b1;
                end
            end

            if (fin_q) begin
                fin_q       <= 1'b0;
                hash_q      <= midstate;
                hash_done_q <= 1'b1;
            end
        end
    end

endmodule
